// File: rtl/dii_pkt_fifo_if.sv
// Flit handshake bundle for dii_pkt_fifo: write side (in_*) and read side (out_*).
// The FIFO takes the slave view; the producer/consumer environment takes the master view.
interface dii_pkt_fifo_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/dii_pkt_fifo.sv
// Circular-pointer flit FIFO with packet tracking, synchronous flush and an optional
// store-and-forward mode that releases oversize packets once the buffer fills.
module dii_pkt_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int FULLPACKET = 0,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  dii_pkt_fifo_if.slave    bus,
  output logic [CNT_W-1:0] level,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] pkt_size
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic              mem_last_q [DEPTH];
  logic [CNT_W-1:0]  len_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] len_wr_q, len_wr_d, len_rd_q, len_rd_d;
  logic [CNT_W-1:0] level_q, level_d, pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0] inc_len_q, inc_len_d, hd_done_q, hd_done_d;
  logic             release_q, release_d;

  logic push, pop, push_last, pop_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign bus.in_ready  = (level_q != CNT_FULL);
  assign bus.out_valid = (FULLPACKET != 0) ? ((pkt_count_q != '0) || release_q)
                                           : (level_q != '0);
  assign bus.out_data  = mem_data_q[rd_ptr_q];
  assign bus.out_last  = mem_last_q[rd_ptr_q];

  assign push      = bus.in_valid && bus.in_ready;
  assign pop       = bus.out_valid && bus.out_ready;
  assign push_last = push && bus.in_last;
  assign pop_last  = pop && bus.out_last;

  assign level     = level_q;
  assign pkt_count = pkt_count_q;
  assign pkt_size  = ((pkt_count_q != '0) && !release_q)
                   ? (len_mem_q[len_rd_q] - hd_done_q) : '0;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_wr_d    = len_wr_q;
    len_rd_d    = len_rd_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;
    inc_len_d   = inc_len_q;
    hd_done_d   = hd_done_q;
    release_d   = release_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      len_wr_d    = '0;
      len_rd_d    = '0;
      level_d     = '0;
      pkt_count_d = '0;
      inc_len_d   = '0;
      hd_done_d   = '0;
      release_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d  = ptr_inc(wr_ptr_q);
        inc_len_d = push_last ? '0 : inc_len_q + 1'b1;
      end
      if (push_last) len_wr_d = ptr_inc(len_wr_q);
      // hd_done keeps counting while releasing so it matches the full length later
      if (pop) begin
        rd_ptr_d  = ptr_inc(rd_ptr_q);
        hd_done_d = pop_last ? '0 : hd_done_q + 1'b1;
      end
      if (pop_last) len_rd_d = ptr_inc(len_rd_q);
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      case ({push_last, pop_last})
        2'b10:   pkt_count_d = pkt_count_q + 1'b1;
        2'b01:   pkt_count_d = pkt_count_q - 1'b1;
        default: pkt_count_d = pkt_count_q;
      endcase
      if (FULLPACKET != 0) begin
        if (pop_last)
          release_d = 1'b0;
        else if ((level_q == CNT_FULL) && (pkt_count_q == '0))
          release_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_wr_q    <= '0;
      len_rd_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
      inc_len_q   <= '0;
      hd_done_q   <= '0;
      release_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_wr_q    <= len_wr_d;
      len_rd_q    <= len_rd_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      inc_len_q   <= inc_len_d;
      hd_done_q   <= hd_done_d;
      release_q   <= release_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem_data_q[wr_ptr_q] <= bus.in_data;
      mem_last_q[wr_ptr_q] <= bus.in_last;
    end
    if (!rst && !flush && push_last) len_mem_q[len_wr_q] <= inc_len_q + 1'b1;
  end
endmodule

// File: tb/tb_dii_pkt_fifo.sv
// Bench for dii_pkt_fifo: three configurations share one stimulus set, sel picks the one observed.
module tb_dii_pkt_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rs, fl, l, v, rdy;
  logic [15:0] d;
  int unsigned sel;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;

  dii_pkt_fifo_if #(.DATA_W(16)) b0 ();
  dii_pkt_fifo_if #(.DATA_W(16)) b1 ();
  dii_pkt_fifo_if #(.DATA_W(16)) b2 ();

  assign b0.in_data = d;  assign b0.in_last = l;  assign b0.in_valid = v;  assign b0.out_ready = rdy;
  assign b1.in_data = d;  assign b1.in_last = l;  assign b1.in_valid = v;  assign b1.out_ready = rdy;
  assign b2.in_data = d;  assign b2.in_last = l;  assign b2.in_valid = v;  assign b2.out_ready = rdy;

  logic [3:0] lvl0, pc0, ps0, lvl1, pc1, ps1;
  logic [2:0] lvl2, pc2, ps2;

  dii_pkt_fifo #(.DATA_W(16), .DEPTH(8), .FULLPACKET(0)) u0 (
    .clk(clk), .rst(rs), .flush(fl), .bus(b0), .level(lvl0), .pkt_count(pc0), .pkt_size(ps0));
  dii_pkt_fifo #(.DATA_W(16), .DEPTH(8), .FULLPACKET(1)) u1 (
    .clk(clk), .rst(rs), .flush(fl), .bus(b1), .level(lvl1), .pkt_count(pc1), .pkt_size(ps1));
  dii_pkt_fifo #(.DATA_W(16), .DEPTH(4), .FULLPACKET(1)) u2 (
    .clk(clk), .rst(rs), .flush(fl), .bus(b2), .level(lvl2), .pkt_count(pc2), .pkt_size(ps2));

  logic        o_valid, o_last, i_ready;
  logic [15:0] o_data;
  logic [3:0]  lvl, pc, ps;
  int          dep_s, fp_s;

  always_comb begin
    case (sel)
      0: begin
        o_valid = b0.out_valid; o_last = b0.out_last; i_ready = b0.in_ready; o_data = b0.out_data;
        lvl = lvl0; pc = pc0; ps = ps0; dep_s = 8; fp_s = 0;
      end
      1: begin
        o_valid = b1.out_valid; o_last = b1.out_last; i_ready = b1.in_ready; o_data = b1.out_data;
        lvl = lvl1; pc = pc1; ps = ps1; dep_s = 8; fp_s = 1;
      end
      default: begin
        o_valid = b2.out_valid; o_last = b2.out_last; i_ready = b2.in_ready; o_data = b2.out_data;
        lvl = {1'b0, lvl2}; pc = {1'b0, pc2}; ps = {1'b0, ps2}; dep_s = 4; fp_s = 1;
      end
    endcase
  end

  // Structural invariants on the observed instance
  always @(negedge clk) begin
    if (mon_en && !rs) begin
      n_tests++;
      if (int'(lvl) > dep_s || pc > lvl || (int'(lvl) == dep_s && i_ready) || (lvl == 0 && o_valid)) begin
        n_fail++;
        $display("FAIL invariant sel=%0d: level=%0d pkt_count=%0d in_ready=%0b out_valid=%0b depth=%0d",
                 sel, lvl, pc, i_ready, o_valid, dep_s);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rs = 1'b1; fl = 1'b0; v = 1'b0; l = 1'b0; rdy = 1'b0; d = '0;
    tick();
    rs = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_tests++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1 || lvl !== 4'd0 || pc !== 4'd0 || ps !== 4'd0) begin
        n_fail++;
        $display("FAIL reset sel=%0d: valid=%0b ready=%0b level=%0d pc=%0d ps=%0d, want 0 1 0 0 0",
                 s, o_valid, i_ready, lvl, pc, ps);
      end
    end
  endtask

  task automatic test_single();
    sel = 0; do_reset();
    d = 16'hA5A5; l = 1'b1; v = 1'b1; tick(); v = 1'b0; l = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 16'hA5A5) begin
      n_fail++; $display("FAIL single_data: valid=%0b data=%h, want 1 a5a5", o_valid, o_data);
    end
    n_tests++;
    if (lvl !== 4'd1 || pc !== 4'd1 || ps !== 4'd1) begin
      n_fail++; $display("FAIL single_status: level=%0d pc=%0d ps=%0d, want 1 1 1", lvl, pc, ps);
    end
  endtask

  task automatic test_fill_wrap();
    int nin, nout;
    sel = 0; do_reset(); rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = 16'(32'h100 + i); l = (i % 4 == 3); v = 1'b1; tick();
    end
    v = 1'b0;
    n_tests++;
    if (i_ready !== 1'b0 || lvl !== 4'd8 || pc !== 4'd2) begin
      n_fail++; $display("FAIL fill_status: ready=%0b level=%0d pc=%0d, want 0 8 2", i_ready, lvl, pc);
    end
    nin = 8; nout = 0; v = 1'b1; rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      d = 16'(32'h100 + nin); l = (nin % 4 == 3);
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== 16'(32'h100 + nout) || lvl < 4'd7 || lvl > 4'd8) begin
        n_fail++;
        $display("FAIL wrap_stream c=%0d: valid=%0b data=%h level=%0d, want 1 %h 7..8",
                 c, o_valid, o_data, lvl, 16'(32'h100 + nout));
      end
      if (i_ready) nin++;
      nout++;
      tick();
    end
    v = 1'b0; rdy = 1'b0;
  endtask

  task automatic test_store_forward();
    sel = 1; do_reset();
    for (int i = 0; i < 3; i++) begin
      d = 16'(32'h200 + i); l = (i == 2); v = 1'b1; tick();
      n_tests++;
      if (o_valid !== (i == 2)) begin
        n_fail++; $display("FAIL sf_valid flit=%0d: valid=%0b want %0b", i, o_valid, (i == 2));
      end
    end
    v = 1'b0; l = 1'b0;
    n_tests++;
    if (ps !== 4'd3 || o_data !== 16'h200) begin
      n_fail++; $display("FAIL sf_size0: ps=%0d data=%h want 3 0200", ps, o_data);
    end
    for (int k = 1; k <= 2; k++) begin
      rdy = 1'b1; tick(); rdy = 1'b0;
      n_tests++;
      if (ps !== 4'(3 - k) || o_data !== 16'(32'h200 + k) || o_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sf_size pops=%0d: ps=%0d data=%h valid=%0b want %0d %h 1",
                 k, ps, o_data, o_valid, 3 - k, 16'(32'h200 + k));
      end
    end
  endtask

  task automatic test_oversize();
    int nin, nout, full_at;
    sel = 2; do_reset(); rdy = 1'b1;
    nin = 0; nout = 0; full_at = -1;
    for (int c = 0; c < 40; c++) begin
      v = (nin < 6); d = 16'(32'h300 + nin); l = (nin == 5);
      if (full_at >= 0 && c == full_at + 1) begin
        n_tests++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ovs_rise: valid=%0b want 1", o_valid); end
      end
      if (lvl == 4'd4 && full_at < 0) begin
        full_at = c;
        n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ovs_early: valid=%0b want 0", o_valid); end
      end
      if (o_valid) begin
        n_tests++;
        if (o_data !== 16'(32'h300 + nout) || ps !== 4'd0 || o_last !== (nout == 5)) begin
          n_fail++;
          $display("FAIL ovs_data n=%0d: data=%h ps=%0d last=%0b want %h 0 %0b",
                   nout, o_data, ps, o_last, 16'(32'h300 + nout), (nout == 5));
        end
        nout++;
      end
      if (v && i_ready) nin++;
      tick();
    end
    rdy = 1'b0; v = 1'b0; l = 1'b0;
    n_tests++;
    if (nout != 6 || full_at < 0 || o_valid !== 1'b0 || pc !== 4'd0 || lvl !== 4'd0) begin
      n_fail++;
      $display("FAIL ovs_end: popped=%0d full_seen=%0d valid=%0b pc=%0d level=%0d want 6 1 0 0 0",
               nout, (full_at >= 0), o_valid, pc, lvl);
    end
  endtask

  task automatic test_simul_last();
    sel = 1; do_reset(); rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = (i < 2) ? 16'(32'h400 + i) : 16'(32'h500 + i - 2); l = (i == 1); v = 1'b1; tick();
    end
    v = 1'b0; l = 1'b0;
    n_tests++;
    if (pc !== 4'd1 || ps !== 4'd2) begin
      n_fail++; $display("FAIL simul_pre: pc=%0d ps=%0d want 1 2", pc, ps);
    end
    rdy = 1'b1; tick(); rdy = 1'b0;
    n_tests++;
    if (ps !== 4'd1) begin n_fail++; $display("FAIL simul_mid: ps=%0d want 1", ps); end
    d = 16'h502; l = 1'b1; v = 1'b1; rdy = 1'b1; tick(); v = 1'b0; l = 1'b0; rdy = 1'b0;
    n_tests++;
    if (pc !== 4'd1 || ps !== 4'd3 || o_data !== 16'h500 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_post: pc=%0d ps=%0d data=%h valid=%0b want 1 3 0500 1", pc, ps, o_data, o_valid);
    end
  endtask

  task automatic test_flush_reset();
    for (int mode = 0; mode < 2; mode++) begin
      sel = 0; do_reset(); rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
        d = 16'(32'h600 + i); l = (i == 1); v = 1'b1; tick();
      end
      n_tests++;
      if (lvl !== 4'd5 || pc !== 4'd1) begin
        n_fail++; $display("FAIL clr_pre mode=%0d: level=%0d pc=%0d want 5 1", mode, lvl, pc);
      end
      d = 16'h666; l = 1'b1; v = 1'b1; rdy = 1'b1;
      if (mode == 0) fl = 1'b1; else rs = 1'b1;
      tick();
      fl = 1'b0; rs = 1'b0; v = 1'b0; l = 1'b0; rdy = 1'b0;
      n_tests++;
      if (lvl !== 4'd0 || pc !== 4'd0 || o_valid !== 1'b0 || i_ready !== 1'b1 || ps !== 4'd0) begin
        n_fail++;
        $display("FAIL clr_post mode=%0d: level=%0d pc=%0d valid=%0b ready=%0b ps=%0d want 0 0 0 1 0",
                 mode, lvl, pc, o_valid, i_ready, ps);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] q[$];
    int          lens[$];
    logic [16:0] f;
    int          m_inc, m_hd, e_ps;
    bit          m_rel, set_rel, push, pop, e_valid, e_ready;
    for (int s = 0; s < 3; s++) begin
      sel = s; do_reset();
      q.delete(); lens.delete(); m_inc = 0; m_hd = 0; m_rel = 1'b0;
      for (int c = 0; c < 400; c++) begin
        e_ready = (q.size() != dep_s);
        e_valid = (fp_s != 0) ? (lens.size() != 0 || m_rel) : (q.size() != 0);
        e_ps    = (lens.size() != 0 && !m_rel) ? lens[0] - m_hd : 0;
        n_tests++;
        if (int'(lvl) != q.size() || int'(pc) != lens.size() || int'(ps) != e_ps ||
            i_ready !== e_ready || o_valid !== e_valid ||
            (e_valid && {o_last, o_data} !== q[0])) begin
          n_fail++;
          $display("FAIL rand sel=%0d c=%0d: lvl=%0d pc=%0d ps=%0d rdy=%0b val=%0b head=%h want %0d %0d %0d %0b %0b %h",
                   s, c, lvl, pc, ps, i_ready, o_valid, {o_last, o_data},
                   q.size(), lens.size(), e_ps, e_ready, e_valid, e_valid ? q[0] : 17'h0);
        end
        fl  = ($urandom_range(0, 63) == 0);
        v   = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 99) < (((c / 100) % 2 == 1) ? 80 : 25));
        l   = ($urandom_range(0, 3) == 0) || (m_inc >= 5);
        d   = 16'($urandom);
        push = v && e_ready;
        pop  = e_valid && rdy;
        set_rel = (fp_s != 0) && (q.size() == dep_s) && (lens.size() == 0);
        tick();
        if (fl) begin
          q.delete(); lens.delete(); m_inc = 0; m_hd = 0; m_rel = 1'b0;
        end else begin
          if (pop) begin
            f = q.pop_front();
            m_hd++;
            if (f[16]) begin
              void'(lens.pop_front()); m_hd = 0; m_rel = 1'b0;
            end else if (set_rel) m_rel = 1'b1;
          end else if (set_rel) m_rel = 1'b1;
          if (push) begin
            q.push_back({l, d});
            m_inc++;
            if (l) begin lens.push_back(m_inc); m_inc = 0; end
          end
        end
      end
      fl = 1'b0; v = 1'b0; rdy = 1'b0;
    end
  endtask

  initial begin
    sel = 0;
    rs = 1'b1; fl = 1'b0; v = 1'b0; l = 1'b0; rdy = 1'b0; d = '0;
    test_reset();
    test_single();
    test_fill_wrap();
    test_store_forward();
    test_oversize();
    test_simul_last();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
